// File: rtl/algo_cali_cluster_p_if.sv
// Avalon-ST stream bundle: used once as the sample sink and once as the result source.
interface algo_cali_cluster_p_if;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic [1:0]  empty;
    logic        startofpacket;
    logic        endofpacket;

    modport master (output data, valid, empty, startofpacket, endofpacket, input ready);
    modport slave  (input data, valid, empty, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/algo_cali_cluster_p.sv
// Calibrates each channel of a sample packet against a RAM factor, finds runs of
// channels above threshold (clusters) and reports count plus the largest cluster.
module algo_cali_cluster_p #(
    parameter int WORDS_PER_PKT = 163,
    parameter int SAMPLE_W      = 16,
    parameter int ADDR_W        = 9,
    parameter int CALI_SHIFT    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    algo_cali_cluster_p_if.slave  data_in,
    algo_cali_cluster_p_if.master result,
    input  logic [15:0]          CL_THRESHOLD,
    input  logic [15:0]          CL_SIZE,
    input  logic                 cali_en,
    output logic [ADDR_W-1:0]    address,
    output logic                 clken,
    input  logic [15:0]          cali_fac,
    output logic                 pkt_err
);
    localparam int SPW    = 32 / SAMPLE_W;
    localparam int SPW_LG = $clog2(SPW);
    localparam int PRODW  = SAMPLE_W + 16;
    localparam int LAST_W = WORDS_PER_PKT - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCEPT  = 3'd1,
        CALC    = 3'd2,
        REPORT0 = 3'd3,
        REPORT1 = 3'd4
    } state_e;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [15:0] clamp16(input logic [PRODW-1:0] v);
        return (|(v >> 16)) ? 16'hFFFF : v[15:0];
    endfunction

    state_e             state_q, state_d;
    logic               ready_q, ready_d;
    logic [2:0]         phase_q, phase_d;
    logic [15:0]        word_idx_q, word_idx_d;
    logic [31:0]        word_sh_q, word_sh_d;
    logic               eop_flag_q, eop_flag_d;
    logic [15:0]        thr_q, thr_d, size_q, size_d;
    logic               en_q, en_d;
    logic [15:0]        run_len_q, run_len_d, run_start_q, run_start_d, run_sum_q, run_sum_d;
    logic [15:0]        cnt_q, cnt_d, big_len_q, big_len_d;
    logic [15:0]        big_start_q, big_start_d, big_sum_q, big_sum_d;
    logic [ADDR_W-1:0]  address_q, address_d;
    logic               clken_q, clken_d, pkt_err_q, pkt_err_d;
    logic               res_valid_q, res_valid_d, res_sop_q, res_sop_d, res_eop_q, res_eop_d;
    logic [31:0]        res_data_q, res_data_d;

    logic [SAMPLE_W-1:0] sample_s;
    logic [PRODW-1:0]    prod_s;
    logic [15:0]         cal_s, chan_base_s, chan_proc_s, size_eff_s;
    logic [15:0]         cl_len_s, cl_start_s, cl_sum_s;
    logic                hit_s, last_word_s, last_chan_s, close_s, qual_s;
    logic                capture_s, en_sel_s;
    logic [1:0]          unused_empty_s;

    // The factor for a sample arrives one cycle after its clken, i.e. exactly when
    // that sample sits at the bottom of the shift register.
    assign sample_s    = word_sh_q[SAMPLE_W-1:0];
    assign prod_s      = PRODW'(sample_s) * PRODW'(cali_fac);
    assign cal_s       = en_q ? clamp16(prod_s >> CALI_SHIFT) : clamp16(PRODW'(sample_s));
    assign chan_base_s = word_idx_q << SPW_LG;
    assign chan_proc_s = chan_base_s + 16'(phase_q) - 16'd1;
    assign size_eff_s  = (size_q == 16'd0) ? 16'd1 : size_q;
    assign hit_s       = cal_s > thr_q;
    assign cl_len_s    = hit_s ? run_len_q + 16'd1 : run_len_q;
    assign cl_start_s  = (hit_s && (run_len_q == 16'd0)) ? chan_proc_s : run_start_q;
    assign cl_sum_s    = hit_s ? sat_add16(run_sum_q, cal_s) : run_sum_q;
    assign last_word_s = (word_idx_q == 16'(LAST_W)) || eop_flag_q;
    assign last_chan_s = (phase_q == 3'(SPW)) && last_word_s;
    assign close_s     = !hit_s || last_chan_s;
    assign qual_s      = cl_len_s >= size_eff_s;
    assign capture_s   = ready_q && data_in.valid && (data_in.startofpacket || (state_q == ACCEPT));
    assign en_sel_s    = data_in.startofpacket ? cali_en : en_q;
    assign unused_empty_s = data_in.empty;

    assign data_in.ready        = ready_q;
    assign result.valid         = res_valid_q;
    assign result.data          = res_data_q;
    assign result.startofpacket = res_sop_q;
    assign result.endofpacket   = res_eop_q;
    assign result.empty         = 2'b00;
    assign address              = address_q;
    assign clken                = clken_q;
    assign pkt_err              = pkt_err_q;

    // Next-state, cluster tracking and output-register update.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        word_idx_d  = word_idx_q;
        word_sh_d   = word_sh_q;
        eop_flag_d  = eop_flag_q;
        thr_d       = thr_q;
        size_d      = size_q;
        en_d        = en_q;
        run_len_d   = run_len_q;
        run_start_d = run_start_q;
        run_sum_d   = run_sum_q;
        cnt_d       = cnt_q;
        big_len_d   = big_len_q;
        big_start_d = big_start_q;
        big_sum_d   = big_sum_q;
        address_d   = address_q;
        clken_d     = 1'b0;
        pkt_err_d   = 1'b0;
        res_valid_d = res_valid_q;
        res_sop_d   = res_sop_q;
        res_eop_d   = res_eop_q;
        res_data_d  = res_data_q;
        case (state_q)
            IDLE, ACCEPT: begin
                if (capture_s) begin
                    state_d    = CALC;
                    phase_d    = 3'd0;
                    word_sh_d  = data_in.data;
                    eop_flag_d = data_in.endofpacket;
                    clken_d    = en_sel_s;
                    if (data_in.startofpacket) begin
                        // A start in ACCEPT abandons the packet in flight.
                        pkt_err_d   = (state_q == ACCEPT);
                        word_idx_d  = 16'd0;
                        thr_d       = CL_THRESHOLD;
                        size_d      = CL_SIZE;
                        en_d        = cali_en;
                        run_len_d   = 16'd0;
                        run_start_d = 16'd0;
                        run_sum_d   = 16'd0;
                        cnt_d       = 16'd0;
                        big_len_d   = 16'd0;
                        big_start_d = 16'd0;
                        big_sum_d   = 16'd0;
                        address_d   = {ADDR_W{1'b0}};
                    end else begin
                        word_idx_d = word_idx_q + 16'd1;
                        address_d  = ADDR_W'((word_idx_q + 16'd1) << SPW_LG);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            CALC: begin
                phase_d = phase_q + 3'd1;
                if (phase_q < 3'(SPW - 1)) begin
                    clken_d   = en_q;
                    address_d = ADDR_W'(chan_base_s + 16'(phase_q) + 16'd1);
                end else begin
                    clken_d = 1'b0;
                end
                if (phase_q != 3'd0) begin
                    word_sh_d = word_sh_q >> SAMPLE_W;
                    if (close_s) begin
                        run_len_d   = 16'd0;
                        run_start_d = 16'd0;
                        run_sum_d   = 16'd0;
                        if (qual_s) begin
                            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                            // Strictly greater: a tie keeps the earlier cluster.
                            if (cl_len_s > big_len_q) begin
                                big_len_d   = cl_len_s;
                                big_start_d = cl_start_s;
                                big_sum_d   = cl_sum_s;
                            end else begin
                                big_len_d = big_len_q;
                            end
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end else begin
                        run_len_d   = cl_len_s;
                        run_start_d = cl_start_s;
                        run_sum_d   = cl_sum_s;
                    end
                end else begin
                    word_sh_d = word_sh_q;
                end
                if (phase_q == 3'(SPW)) begin
                    pkt_err_d = eop_flag_q ^ (word_idx_q == 16'(LAST_W));
                    if (last_word_s) begin
                        state_d     = REPORT0;
                        res_valid_d = 1'b1;
                        res_sop_d   = 1'b1;
                        res_eop_d   = 1'b0;
                        res_data_d  = {cnt_d, big_len_d};
                    end else begin
                        state_d = ACCEPT;
                    end
                end else begin
                    state_d = CALC;
                end
            end
            REPORT0: begin
                if (result.ready) begin
                    state_d    = REPORT1;
                    res_sop_d  = 1'b0;
                    res_eop_d  = 1'b1;
                    res_data_d = {big_start_q, big_sum_q};
                end else begin
                    state_d = REPORT0;
                end
            end
            REPORT1: begin
                if (result.ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                    res_eop_d   = 1'b0;
                    res_data_d  = 32'd0;
                end else begin
                    state_d = REPORT1;
                end
            end
            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
                res_sop_d   = 1'b0;
                res_eop_d   = 1'b0;
            end
        endcase
        ready_d = (state_d == IDLE) || (state_d == ACCEPT);
    end

    // State and datapath registers; reset discards any packet or report in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            phase_q     <= 3'd0;
            word_idx_q  <= 16'd0;
            word_sh_q   <= 32'd0;
            eop_flag_q  <= 1'b0;
            thr_q       <= 16'd0;
            size_q      <= 16'd0;
            en_q        <= 1'b0;
            run_len_q   <= 16'd0;
            run_start_q <= 16'd0;
            run_sum_q   <= 16'd0;
            cnt_q       <= 16'd0;
            big_len_q   <= 16'd0;
            big_start_q <= 16'd0;
            big_sum_q   <= 16'd0;
            address_q   <= {ADDR_W{1'b0}};
            clken_q     <= 1'b0;
            pkt_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_sop_q   <= 1'b0;
            res_eop_q   <= 1'b0;
            res_data_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            phase_q     <= phase_d;
            word_idx_q  <= word_idx_d;
            word_sh_q   <= word_sh_d;
            eop_flag_q  <= eop_flag_d;
            thr_q       <= thr_d;
            size_q      <= size_d;
            en_q        <= en_d;
            run_len_q   <= run_len_d;
            run_start_q <= run_start_d;
            run_sum_q   <= run_sum_d;
            cnt_q       <= cnt_d;
            big_len_q   <= big_len_d;
            big_start_q <= big_start_d;
            big_sum_q   <= big_sum_d;
            address_q   <= address_d;
            clken_q     <= clken_d;
            pkt_err_q   <= pkt_err_d;
            res_valid_q <= res_valid_d;
            res_sop_q   <= res_sop_d;
            res_eop_q   <= res_eop_d;
            res_data_q  <= res_data_d;
        end
    end
endmodule

// File: tb/tb_algo_cali_cluster_p.sv
// Randomized bench for algo_cali_cluster_p against a channel-list reference model.
module tb_algo_cali_cluster_p;
    localparam int WORDS = 163;
    localparam int NCH   = 326;
    localparam int SHIFT = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cl_thr, cl_size;
    logic        cali_en;
    logic [8:0]  address;
    logic        clken;
    logic [15:0] cali_fac = 16'd0;
    logic        pkt_err;

    algo_cali_cluster_p_if din_if();
    algo_cali_cluster_p_if res_if();

    logic [15:0] samp [0:NCH-1];
    logic [15:0] ram  [0:511];
    int          n_checks = 0;
    int          n_fail = 0;
    int          err_cnt = 0;
    int          clken_cnt = 0;
    logic [33:0] rq [$];

    always #5 clk = ~clk;

    algo_cali_cluster_p dut (
        .clk          (clk),
        .rst          (rst_n),
        .data_in      (din_if),
        .result       (res_if),
        .CL_THRESHOLD (cl_thr),
        .CL_SIZE      (cl_size),
        .cali_en      (cali_en),
        .address      (address),
        .clken        (clken),
        .cali_fac     (cali_fac),
        .pkt_err      (pkt_err)
    );

    // Calibration RAM: data one cycle after clken.
    always @(posedge clk) if (clken) cali_fac <= ram[address];

    // Monitors: error pulses, RAM reads and accepted result beats.
    always @(negedge clk) begin
        if (pkt_err) err_cnt <= err_cnt + 1;
        if (clken) clken_cnt <= clken_cnt + 1;
        if (res_if.valid && res_if.ready)
            rq.push_back({res_if.startofpacket, res_if.endofpacket, res_if.data});
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic sop, input logic eop);
        int t = 0;
        din_if.data = d;
        din_if.valid = 1'b1;
        din_if.startofpacket = sop;
        din_if.endofpacket = eop;
        @(negedge clk);
        while (!din_if.ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check_eq("in_ready_timeout", 64'(t), 64'd0);
        tick();
        din_if.valid = 1'b0;
        din_if.startofpacket = 1'b0;
        din_if.endofpacket = 1'b0;
    endtask

    task automatic send_pkt(input int nwords, input int eop_at);
        for (int w = 0; w < nwords; w++)
            send_word({samp[2*w+1], samp[2*w]}, w == 0, w == eop_at);
    endtask

    // Walk channels in order, tracking the open run of hits.
    function automatic void ref_model(input int nch, output logic [31:0] w0, output logic [31:0] w1);
        longint v;
        int cnt = 0, blen = 0, bstart = 0, bsum = 0, rl = 0, rs = 0, rsum = 0, need;
        need = (cl_size == 16'd0) ? 1 : int'(cl_size);
        for (int c = 0; c < nch; c++) begin
            if (cali_en) begin
                v = (longint'(samp[c]) * longint'(ram[c])) >> SHIFT;
                if (v > 65535) v = 65535;
            end else begin
                v = longint'(samp[c]);
            end
            if (v > longint'(cl_thr)) begin
                if (rl == 0) rs = c;
                rl++;
                rsum = rsum + int'(v);
                if (rsum > 65535) rsum = 65535;
            end
            if (v <= longint'(cl_thr) || c == nch - 1) begin
                if (rl >= need) begin
                    if (cnt < 65535) cnt++;
                    if (rl > blen) begin
                        blen = rl;
                        bstart = rs;
                        bsum = rsum;
                    end
                end
                rl = 0;
                rsum = 0;
            end
        end
        w0 = {16'(cnt), 16'(blen)};
        w1 = {16'(bstart), 16'(bsum)};
    endfunction

    task automatic get_report(output logic [31:0] w0, output logic [31:0] w1);
        int t = 0;
        logic [33:0] b0, b1;
        while (rq.size() < 2 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (rq.size() < 2) begin
            check_eq("report_timeout", 64'(rq.size()), 64'd2);
            w0 = 32'd0;
            w1 = 32'd0;
        end else begin
            b0 = rq.pop_front();
            b1 = rq.pop_front();
            check_eq("beat0_sop_eop", 64'(b0[33:32]), 64'd2);
            check_eq("beat1_sop_eop", 64'(b1[33:32]), 64'd1);
            w0 = b0[31:0];
            w1 = b1[31:0];
        end
    endtask

    task automatic verify(input string tag, input int nch, input int e0, input int exp_err);
        logic [31:0] w0, w1, m0, m1;
        get_report(w0, w1);
        ref_model(nch, m0, m1);
        check_eq({tag, "_w0"}, 64'(w0), 64'(m0));
        check_eq({tag, "_w1"}, 64'(w1), 64'(m1));
        tick();
        check_eq({tag, "_pkt_err"}, 64'(err_cnt - e0), 64'(exp_err));
    endtask

    task automatic rand_fill(input int smax, input int fmax);
        for (int c = 0; c < NCH; c++) samp[c] = 16'($urandom_range(0, smax));
        for (int a = 0; a < 512; a++) ram[a] = 16'($urandom_range(0, fmax));
    endtask

    initial begin
        int e0, c0, t;
        logic [31:0] d0;
        rst_n = 1'b0;
        din_if.valid = 1'b0;
        din_if.data = 32'd0;
        din_if.startofpacket = 1'b0;
        din_if.endofpacket = 1'b0;
        din_if.empty = 2'b00;
        res_if.ready = 1'b1;
        cl_thr = 16'd0;
        cl_size = 16'd0;
        cali_en = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 64'(din_if.ready), 64'd0);
        check_eq("rst_res_valid", 64'(res_if.valid), 64'd0);
        check_eq("rst_clken", 64'(clken), 64'd0);
        check_eq("rst_address", 64'(address), 64'd0);
        check_eq("rst_pkt_err", 64'(pkt_err), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("ready_after_rst", 64'(din_if.ready), 64'd1);
        tick();

        for (int c = 0; c < NCH; c++) samp[c] = 16'd1;
        for (int a = 0; a < 512; a++) ram[a] = 16'd3;
        cl_thr = 16'd2; cl_size = 16'd5; cali_en = 1'b1;
        e0 = err_cnt;
        send_pkt(WORDS, WORDS - 1);
        verify("all_ones", NCH, e0, 0);

        for (int c = 0; c < NCH; c++) samp[c] = 16'd0;
        for (int c = 10; c <= 14; c++) samp[c] = 16'd5;
        for (int c = 40; c <= 42; c++) samp[c] = 16'd9;
        cali_en = 1'b0;
        e0 = err_cnt; c0 = clken_cnt;
        send_pkt(WORDS, WORDS - 1);
        verify("two_runs", NCH, e0, 0);
        check_eq("no_ram_reads", 64'(clken_cnt - c0), 64'd0);

        for (int c = 0; c < NCH; c++) samp[c] = (c < 6) ? 16'hFFFF : 16'd0;
        for (int a = 0; a < 512; a++) ram[a] = 16'hFFFF;
        cali_en = 1'b1;
        e0 = err_cnt;
        send_pkt(WORDS, WORDS - 1);
        verify("saturate", NCH, e0, 0);

        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                rand_fill(65535, 65535);
                cl_thr = 16'($urandom);
                cali_en = 1'b1;
            end else begin
                rand_fill(5, 3);
                cl_thr = 16'($urandom_range(0, 6));
                cali_en = 1'($urandom_range(0, 1));
            end
            cl_size = 16'($urandom_range(0, 4));
            e0 = err_cnt;
            send_pkt(WORDS, WORDS - 1);
            verify($sformatf("rand%0d", i), NCH, e0, 0);
        end

        rand_fill(5, 3);
        cl_thr = 16'd3; cl_size = 16'd2; cali_en = 1'b1;
        res_if.ready = 1'b0;
        e0 = err_cnt;
        send_pkt(WORDS, WORDS - 1);
        t = 0;
        while (!res_if.valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq("stall_valid", 64'(res_if.valid), 64'd1);
        d0 = res_if.data;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("stall_data", 64'(res_if.data), 64'(d0));
            check_eq("stall_in_ready", 64'(din_if.ready), 64'd0);
        end
        tick();
        res_if.ready = 1'b1;
        verify("stall", NCH, e0, 0);

        rand_fill(5, 3);
        e0 = err_cnt;
        send_pkt(51, 50);
        verify("early_eop", 102, e0, 1);

        rand_fill(5, 3);
        e0 = err_cnt;
        send_pkt(WORDS, -1);
        verify("no_eop", NCH, e0, 1);
        e0 = err_cnt;
        send_word(32'h0009_0009, 1'b0, 1'b0);
        send_word(32'h0009_0009, 1'b0, 1'b1);
        repeat (20) tick();
        check_eq("drop_excess_beats", 64'(rq.size()), 64'd0);
        check_eq("drop_excess_err", 64'(err_cnt - e0), 64'd0);

        rand_fill(5, 3);
        e0 = err_cnt;
        send_pkt(30, -1);
        rand_fill(5, 3);
        send_pkt(WORDS, WORDS - 1);
        verify("sop_restart", NCH, e0, 1);
        repeat (10) tick();
        check_eq("sop_restart_single_report", 64'(rq.size()), 64'd0);

        rand_fill(5, 3);
        cali_en = 1'b1;
        send_pkt(80, -1);
        send_word({samp[161], samp[160]}, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_clken", 64'(clken), 64'd0);
        check_eq("midrst_address", 64'(address), 64'd0);
        check_eq("midrst_res_valid", 64'(res_if.valid), 64'd0);
        check_eq("midrst_pkt_err", 64'(pkt_err), 64'd0);
        check_eq("midrst_in_ready", 64'(din_if.ready), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        check_eq("midrst_no_partial", 64'(rq.size()), 64'd0);
        rand_fill(5, 3);
        e0 = err_cnt;
        send_pkt(WORDS, WORDS - 1);
        verify("after_rst", NCH, e0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
